// File: rtl/btn_pkg.sv
// Shared types and 100 MHz default timing for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    LONG
  } btn_state_e;

  localparam int unsigned BTN_SAMPLE_DIV   = 100000;
  localparam int unsigned BTN_DB_SAMPLES   = 4;
  localparam int unsigned BTN_LONG_TICKS   = 500;
  localparam int unsigned BTN_REPEAT_TICKS = 100;

  // Width for a counter spanning 0..n-1; never narrower than one bit.
  function automatic int unsigned btn_cw(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_sync_filter.sv
// Two-flop synchroniser, sample-tick divider and N-sample agreement filter
// producing the debounced button level.
module btn_sync_filter
  import btn_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = BTN_SAMPLE_DIV,
  parameter int unsigned DB_SAMPLES = BTN_DB_SAMPLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic pb_level,
  output logic tick
);

  localparam int unsigned DW = btn_cw(SAMPLE_DIV);

  logic                  r_sync1;
  logic                  r_sync2;
  logic [DW-1:0]         r_div;
  logic [DB_SAMPLES-1:0] r_sreg;
  logic                  r_level;

  logic                  w_tick;
  logic [DB_SAMPLES-1:0] w_sreg_nx;

  assign w_tick    = (r_div == DW'(SAMPLE_DIV - 1));
  assign w_sreg_nx = {r_sreg[DB_SAMPLES-2:0], r_sync2};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_div   <= '0;
      r_sreg  <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync1 <= pb;
      r_sync2 <= r_sync1;
      r_div   <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_sreg <= w_sreg_nx;
        // Level follows only a unanimous window; mixed windows hold it.
        if (&w_sreg_nx) begin
          r_level <= 1'b1;
        end else if (~|w_sreg_nx) begin
          r_level <= 1'b0;
        end
      end
    end
  end

  assign pb_level = r_level;
  assign tick     = w_tick;

endmodule

// File: rtl/btn_conditioner.sv
// Debounced level, press/release strobes and long-hold detection for one button.
// Define BTN_AUTOREPEAT_EN to add auto-repeat pulses while the button stays held.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV   = BTN_SAMPLE_DIV,
  parameter int unsigned DB_SAMPLES   = BTN_DB_SAMPLES,
  parameter int unsigned LONG_TICKS   = BTN_LONG_TICKS,
  parameter int unsigned REPEAT_TICKS = BTN_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic pb_level,
  output logic pb_press,
  output logic pb_release,
  output logic pb_long,
  output logic pb_repeat
);

  localparam int unsigned HW = btn_cw(LONG_TICKS);

  if (SAMPLE_DIV < 2 || DB_SAMPLES < 2 || LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
    $error("btn_conditioner: timing parameter out of range");
  end

  logic       w_level;
  logic       w_tick;
  logic       w_rise;
  logic       w_fall;
  logic       r_level_d;
  logic       r_press;
  logic       r_release;
  logic       r_long;
  logic       w_long_nx;
  btn_state_e r_state;
  btn_state_e w_state_nx;
  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_hold_nx;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RW = btn_cw(REPEAT_TICKS);
  logic [RW-1:0] r_rep;
  logic [RW-1:0] w_rep_nx;
  logic          r_repeat;
  logic          w_repeat_nx;
`endif

  btn_sync_filter #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .DB_SAMPLES(DB_SAMPLES)
  ) u_filter (
    .clk     (clk),
    .rst     (rst),
    .pb      (pb),
    .pb_level(w_level),
    .tick    (w_tick)
  );

  // The FSM reacts to the edge condition itself, so the registered strobes and
  // the FSM outputs change on the same clock edge.
  assign w_rise = w_level & ~r_level_d;
  assign w_fall = ~w_level & r_level_d;

  always_comb begin
    w_state_nx = r_state;
    w_hold_nx  = r_hold;
    w_long_nx  = r_long;
`ifdef BTN_AUTOREPEAT_EN
    w_rep_nx    = r_rep;
    w_repeat_nx = 1'b0;
`endif
    if (w_fall) begin
      w_state_nx = IDLE;
      w_long_nx  = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            w_state_nx = PRESS;
            w_hold_nx  = '0;
          end
        end
        PRESS: begin
          if (w_tick) begin
            if (r_hold == HW'(LONG_TICKS - 1)) begin
              w_state_nx = LONG;
              w_long_nx  = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
              w_repeat_nx = 1'b1;
              w_rep_nx    = '0;
`endif
            end else begin
              w_hold_nx = r_hold + 1'b1;
            end
          end
        end
        LONG: begin
`ifdef BTN_AUTOREPEAT_EN
          if (w_tick) begin
            if (r_rep == RW'(REPEAT_TICKS - 1)) begin
              w_repeat_nx = 1'b1;
              w_rep_nx    = '0;
            end else begin
              w_rep_nx = r_rep + 1'b1;
            end
          end
`endif
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_hold    <= '0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      r_rep    <= '0;
      r_repeat <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nx;
      r_hold    <= w_hold_nx;
      r_level_d <= w_level;
      r_press   <= w_rise;
      r_release <= w_fall;
      r_long    <= w_long_nx;
`ifdef BTN_AUTOREPEAT_EN
      r_rep    <= w_rep_nx;
      r_repeat <= w_repeat_nx;
`endif
    end
  end

  assign pb_level   = w_level;
  assign pb_press   = r_press;
  assign pb_release = r_release;
  assign pb_long    = r_long;
`ifdef BTN_AUTOREPEAT_EN
  assign pb_repeat  = r_repeat;
`else
  assign pb_repeat  = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: a timeline model predicts every output
// change, a monitor compares each observed change, directed scenarios add bounds.
module tb_btn_conditioner;

  localparam int SD = 4;
  localparam int DB = 4;
  localparam int LT = 5;
  localparam int RT = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pb  = 1'b0;
  logic pb_level, pb_press, pb_release, pb_long, pb_repeat;

  btn_conditioner #(
    .SAMPLE_DIV  (SD),
    .DB_SAMPLES  (DB),
    .LONG_TICKS  (LT),
    .REPEAT_TICKS(RT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pb        (pb),
    .pb_level  (pb_level),
    .pb_press  (pb_press),
    .pb_release(pb_release),
    .pb_long   (pb_long),
    .pb_repeat (pb_repeat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] vec;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_press = 0;
  int   n_rel   = 0;
  int   n_rep   = 0;

  // Reference timeline: edge index since reset, raw pb history, sample window.
  int         m_k;
  bit         m_pbq[$];
  bit         m_win[$];
  bit         m_lvl, m_lvl1, m_held, m_long, m_in_rst;
  int         m_ticks;
  logic [4:0] m_prev = '0;
  logic [4:0] m_before = '0;
  logic [4:0] mon_prev = '0;

  function automatic logic [4:0] outs();
    return {pb_level, pb_press, pb_release, pb_long, pb_repeat};
  endfunction

  function automatic logic sig(input int which);
    case (which)
      0:       return pb_level;
      1:       return pb_press;
      2:       return pb_release;
      default: return pb_long;
    endcase
  endfunction

  task automatic model_clear();
    m_k = 0;
    m_pbq.delete();
    m_win.delete();
    for (int i = 0; i < DB; i++) m_win.push_back(1'b0);
    m_lvl = 0; m_lvl1 = 0; m_held = 0; m_long = 0; m_ticks = 0;
  endtask

  task automatic model_step();
    bit smp, newlvl, pr, rl, rep, tick;
    int ones;
    logic [4:0] vec;
    m_k++;
    tick = (m_k % SD) == 0;
    m_pbq.push_back(pb);
    if (m_pbq.size() > 3) void'(m_pbq.pop_front());
    smp = (m_pbq.size() == 3) ? m_pbq[0] : 1'b0;
    pr = m_lvl && !m_lvl1;
    rl = !m_lvl && m_lvl1;
    newlvl = m_lvl;
    if (tick) begin
      m_win.push_back(smp);
      void'(m_win.pop_front());
      ones = 0;
      foreach (m_win[i]) ones += int'(m_win[i]);
      if (ones == DB) newlvl = 1'b1;
      else if (ones == 0) newlvl = 1'b0;
    end
    m_lvl1 = m_lvl;
    m_lvl  = newlvl;
    rep = 1'b0;
    if (rl) begin
      m_held = 0; m_long = 0;
    end else if (pr) begin
      m_held = 1; m_ticks = 0;
    end else if (m_held && tick) begin
      m_ticks++;
      if (m_ticks == LT) begin
        m_long = 1; rep = REP_EN;
      end else if (m_ticks > LT && ((m_ticks - LT) % RT) == 0) begin
        rep = REP_EN;
      end
    end
    vec = {m_lvl, pr, rl, m_long, rep};
    if (vec != m_prev) begin
      sbq.push_back('{cyc, vec});
      m_prev = vec;
    end
  endtask

  task automatic chk(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s got %0d want %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // n = cycles until the output is seen high; maxc+1 when the bound expires.
  task automatic wait_for(input int which, input int maxc, output int n);
    n = maxc + 1;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk);
      #1;
      if (sig(which)) begin
        n = i;
        break;
      end
    end
  endtask

  int n, n1, n2, pr0, rl0, rp0, rp1;

  initial begin
    model_clear();
    m_in_rst = 0;
    fork
      begin : model_thr
        forever begin
          @(posedge clk or posedge rst);
          if (rst && !m_in_rst) begin
            // Asynchronous reset: replace anything predicted for this cycle.
            m_in_rst = 1;
            if (sbq.size() > 0 && sbq[$].cyc == cyc) begin
              void'(sbq.pop_back());
              m_prev = m_before;
            end
            model_clear();
            if (m_prev != 5'b0) begin
              sbq.push_back('{cyc, 5'b0});
              m_prev = 5'b0;
            end
          end else begin
            cyc++;
            m_before = m_prev;
            if (rst) model_clear();
            else begin
              m_in_rst = 0;
              model_step();
            end
          end
        end
      end
      begin : monitor_thr
        exp_t       e;
        logic [4:0] obs;
        forever begin
          @(negedge clk);
          obs = outs();
          if (obs !== mon_prev) begin
            checks++;
            if (sbq.size() == 0) begin
              errors++;
              $display("FAIL sb_change cyc=%0d got %b want no change", cyc, obs);
            end else begin
              e = sbq.pop_front();
              if (e.cyc != cyc || e.vec !== obs) begin
                errors++;
                $display("FAIL sb_change got cyc=%0d vec=%b want cyc=%0d vec=%b",
                         cyc, obs, e.cyc, e.vec);
              end
            end
            mon_prev = obs;
          end
          if (pb_repeat) n_rep++;
          if (pb_release) n_rel++;
          if (pb_press) begin
            n_press++;
            checks++;
            if (pb_repeat) begin
              errors++;
              $display("FAIL press_repeat_overlap cyc=%0d got repeat=1 want 0", cyc);
            end
          end
        end
      end
    join_none

    rst = 1'b1;
    pb  = 1'b0;
    cyc_wait(5);
    chk("reset_outputs", int'(outs()), 0, 0);
    rst = 1'b0;

    // Clean press
    cyc_wait(10);
    pr0 = n_press; rl0 = n_rel;
    pb = 1'b1;
    wait_for(0, 40, n);
    chk("clean_level_latency", n, 15, 22);
    wait_for(1, 3, n);
    chk("clean_press_delay", n, 1, 1);
    cyc_wait(12);
    chk("clean_press_count", n_press - pr0, 1, 1);
    chk("clean_no_release", n_rel - rl0, 0, 0);
    chk("clean_no_long", int'(pb_long), 0, 0);
    pb = 1'b0;
    wait_for(2, 40, n);
    chk("clean_release_latency", n, 14, 23);
    cyc_wait(20);

    // Bounce
    pr0 = n_press; rl0 = n_rel;
    for (int i = 0; i < 40; i++) begin
      pb = ((i / 3) % 2) == 0;
      cyc_wait(1);
    end
    pb = 1'b0;
    cyc_wait(30);
    chk("bounce_no_press", n_press - pr0, 0, 0);
    chk("bounce_no_release", n_rel - rl0, 0, 0);
    chk("bounce_level", int'(pb_level), 0, 0);

    // Long hold of 200 cycles, then release during LONG
    rp0 = n_rep;
    pb = 1'b1;
    wait_for(1, 40, n1);
    wait_for(3, 40, n2);
    chk("long_after_press", n2, 16, 24);
    chk("repeat_at_long_rise", int'(pb_repeat), int'(REP_EN), int'(REP_EN));
    cyc_wait(200 - n1 - n2);
    chk("repeat_count", n_rep - rp0, REP_EN ? 13 : 0, REP_EN ? 15 : 0);
    chk("long_held", int'(pb_long), 1, 1);
    rl0 = n_rel;
    pb = 1'b0;
    wait_for(2, 40, n);
    chk("long_release_latency", n, 14, 23);
    chk("long_clears_with_release", int'(pb_long), 0, 0);
    rp1 = n_rep;
    cyc_wait(30);
    chk("no_repeat_after_release", n_rep - rp1, 0, 0);
    chk("single_release", n_rel - rl0, 1, 1);

    // Random activity against the model
    for (int i = 0; i < 25; i++) begin
      pb = 1'($urandom_range(0, 1));
      cyc_wait(int'($urandom_range(1, 40)));
    end
    pb = 1'b0;
    cyc_wait(40);

    // Reset mid-hold with pb still high
    pb = 1'b1;
    wait_for(3, 80, n);
    chk("pre_reset_long", n, 1, 80);
    cyc_wait(5);
    rst = 1'b1;
    #1;
    chk("reset_mid_hold_outputs", int'(outs()), 0, 0);
    cyc_wait(3);
    rst = 1'b0;
    wait_for(1, 40, n);
    chk("press_after_reset", n, 1, 22);
    pb = 1'b0;
    cyc_wait(40);

    cyc_wait(10);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d pending want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
